// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the ALU reservation station.
// Opcode encodings are the single source for decoder, RS and ALU.
package reservation_station_pkg;

  localparam int RS_SIZE = 16;
  localparam int ROB_W   = 4;
  localparam int OPC_W   = 6;
  localparam int IDX_W   = $clog2(RS_SIZE);

  typedef logic [ROB_W-1:0] rob_t;
  typedef logic [OPC_W-1:0] opc_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam opc_t OP_ADD  = 6'd1;
  localparam opc_t OP_SUB  = 6'd2;
  localparam opc_t OP_SLL  = 6'd3;
  localparam opc_t OP_SLT  = 6'd4;
  localparam opc_t OP_SLTU = 6'd5;
  localparam opc_t OP_XOR  = 6'd6;
  localparam opc_t OP_SRL  = 6'd7;
  localparam opc_t OP_SRA  = 6'd8;
  localparam opc_t OP_OR   = 6'd9;
  localparam opc_t OP_AND  = 6'd10;
  localparam opc_t OP_BEQ  = 6'd11;
  localparam opc_t OP_BNE  = 6'd12;
  localparam opc_t OP_BLT  = 6'd13;
  localparam opc_t OP_BGE  = 6'd14;
  localparam opc_t OP_BLTU = 6'd15;
  localparam opc_t OP_JALR = 6'd16;

  typedef struct packed {
    logic        busy;
    logic [31:0] val;
  } operand_t;

  typedef struct packed {
    logic        busy;
    opc_t        opcode;
    rob_t        rob_name;
    logic [31:0] vj;
    logic [31:0] vk;
    rob_t        qj;
    rob_t        qk;
    logic        qj_busy;
    logic        qk_busy;
  } rs_entry_t;

  // ALU CDB has precedence over the LSB bus when both carry the tag
  function automatic operand_t snoop(
    input logic        pend,
    input rob_t        tag,
    input logic [31:0] val,
    input logic        c_sgn,
    input rob_t        c_tag,
    input logic [31:0] c_res,
    input logic        l_sgn,
    input rob_t        l_tag,
    input logic [31:0] l_res
  );
    operand_t o;
    o.busy = pend;
    o.val  = val;
    if (pend && c_sgn && c_tag == tag) begin
      o.busy = 1'b0;
      o.val  = c_res;
    end else if (pend && l_sgn && l_tag == tag) begin
      o.busy = 1'b0;
      o.val  = l_res;
    end
    return o;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder over a request vector.
// Used for both free-slot allocation and ready-entry selection.
module rs_select #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU-side reservation station: buffers micro-ops until both operands
// are resolved via CDB/LSB snooping, then dispatches one per cycle.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        DC_sgn,
  input  opc_t        DC_opcode,
  input  rob_t        DC_ROB_name,
  input  logic [31:0] DC_Vj,
  input  logic        DC_Qj_busy,
  input  rob_t        DC_Qj,
  input  logic [31:0] DC_Vk,
  input  logic        DC_Qk_busy,
  input  rob_t        DC_Qk,
  output logic        RS_full,
  output logic        ALU_sgn,
  output opc_t        ALU_opcode,
  output rob_t        ALU_ROB_name,
  output logic [31:0] ALU_lhs,
  output logic [31:0] ALU_rhs,
  input  logic        CDB_sgn,
  input  rob_t        CDB_ROB_name,
  input  logic [31:0] CDB_result,
  input  logic        LSB_sgn,
  input  rob_t        LSB_ROB_name,
  input  logic [31:0] LSB_result,
  input  logic        ROB_clear
);

  rs_entry_t ent [RS_SIZE];

  logic [RS_SIZE-1:0] free_vec;
  logic [RS_SIZE-1:0] ready_vec;
  idx_t               alloc;
  idx_t               sel;
  logic               has_free;
  logic               has_ready;
  operand_t           wj [RS_SIZE];
  operand_t           wk [RS_SIZE];
  operand_t           ij;
  operand_t           ik;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = ~ent[i].busy;
      ready_vec[i] = ent[i].busy & ~ent[i].qj_busy & ~ent[i].qk_busy;
      wj[i] = snoop(ent[i].qj_busy, ent[i].qj, ent[i].vj,
                    CDB_sgn, CDB_ROB_name, CDB_result,
                    LSB_sgn, LSB_ROB_name, LSB_result);
      wk[i] = snoop(ent[i].qk_busy, ent[i].qk, ent[i].vk,
                    CDB_sgn, CDB_ROB_name, CDB_result,
                    LSB_sgn, LSB_ROB_name, LSB_result);
    end
    ij = snoop(DC_Qj_busy, DC_Qj, DC_Vj,
               CDB_sgn, CDB_ROB_name, CDB_result,
               LSB_sgn, LSB_ROB_name, LSB_result);
    ik = snoop(DC_Qk_busy, DC_Qk, DC_Vk,
               CDB_sgn, CDB_ROB_name, CDB_result,
               LSB_sgn, LSB_ROB_name, LSB_result);
  end

  rs_select #(.N(RS_SIZE)) u_alloc (
    .req   (free_vec),
    .idx   (alloc),
    .found (has_free)
  );

  rs_select #(.N(RS_SIZE)) u_pick (
    .req   (ready_vec),
    .idx   (sel),
    .found (has_ready)
  );

  assign RS_full = ~has_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      ALU_sgn      <= 1'b0;
      ALU_opcode   <= '0;
      ALU_ROB_name <= '0;
      ALU_lhs      <= '0;
      ALU_rhs      <= '0;
    end else if (!rdy) begin
      ALU_sgn <= 1'b0;
    end else if (ROB_clear) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
      ALU_sgn <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent[i].busy) begin
          ent[i].qj_busy <= wj[i].busy;
          ent[i].vj      <= wj[i].val;
          ent[i].qk_busy <= wk[i].busy;
          ent[i].vk      <= wk[i].val;
        end
      end
      ALU_sgn <= has_ready;
      if (has_ready) begin
        ALU_opcode     <= ent[sel].opcode;
        ALU_ROB_name   <= ent[sel].rob_name;
        ALU_lhs        <= ent[sel].vj;
        ALU_rhs        <= ent[sel].vk;
        ent[sel].busy  <= 1'b0;
      end
      // alloc is a registered-free slot, so it never collides with sel
      if (DC_sgn && has_free) begin
        ent[alloc] <= '{
          busy:     1'b1,
          opcode:   DC_opcode,
          rob_name: DC_ROB_name,
          vj:       ij.val,
          vk:       ik.val,
          qj:       DC_Qj,
          qk:       DC_Qk,
          qj_busy:  ij.busy,
          qk_busy:  ik.busy
        };
      end
    end
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Issue-side partner of the ALU: buffers decoded ALU/branch/JALR micro-ops until both operands are known.
- Snoops the ALU and LSB CDBs to resolve operand tags.
- Dispatches at most one ready entry per cycle to the ALU on its RS_* input interface: sgn, opcode, ROB_name, lhs, rhs.
- Sits between the decoder/dispatch stage and the ALU. The ROB can flush it.

Parameters:
RS_SIZE, 16, number of entries
ROB_W, 4, width of a ROB tag (`ROBID)
OPC_W, 6, opcode width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
rdy  in  1  global enable; low freezes state
DC_sgn  in  1  issue request, one micro-op
DC_opcode  in  OPC_W  micro-op opcode
DC_ROB_name  in  ROB_W  destination ROB tag
DC_Vj  in  32  lhs value (valid when DC_Qj_busy=0)
DC_Qj_busy  in  1  lhs still pending
DC_Qj  in  ROB_W  lhs producer tag
DC_Vk  in  32  rhs value/immediate
DC_Qk_busy  in  1  rhs still pending
DC_Qk  in  ROB_W  rhs producer tag
RS_full  out  1  no free entry
ALU_sgn  out  1  dispatch valid, one-cycle pulse
ALU_opcode  out  OPC_W  dispatched opcode
ALU_ROB_name  out  ROB_W  dispatched tag
ALU_lhs  out  32  dispatched lhs
ALU_rhs  out  32  dispatched rhs
CDB_sgn  in  1  ALU broadcast valid
CDB_ROB_name  in  ROB_W  ALU broadcast tag
CDB_result  in  32  ALU broadcast value
LSB_sgn  in  1  LSB broadcast valid
LSB_ROB_name  in  ROB_W  LSB broadcast tag
LSB_result  in  32  LSB broadcast value
ROB_clear  in  1  misprediction flush

Behaviour:
- Reset (rst=0, async): all busy bits=0. ALU_sgn=0. ALU_opcode, ALU_ROB_name, ALU_lhs, ALU_rhs=0. RS_full=0.
- Per-entry state: busy, opcode, ROB_name, Vj, Vk, Qj, Qk, Qj_busy, Qk_busy.
- RS_full is combinational from the registered busy vector: 1 iff all entries are busy.
- rdy=0: no entry state changes and ALU_sgn is cleared to 0 at the edge, so the ALU never re-broadcasts.
- Priority at an edge with rdy=1: ROB_clear > everything else.
  - ROB_clear: all busy=0 and ALU_sgn=0. Same-cycle DC_sgn is dropped.
- Issue: if DC_sgn=1 and RS_full=0, write the lowest-index free entry. Free is judged on registered busy, so a slot freed by this cycle's dispatch is not reused this cycle.
- DC_sgn=1 while RS_full=1 is a protocol violation: the request is ignored and no state changes.
- Issue-time forwarding: if DC_Qj_busy=1 and a valid CDB or LSB tag equals DC_Qj in the same cycle, store that result with Qj_busy=0. Same rule for Qk.
- Wakeup: every busy entry with Qj_busy and Qj==broadcast tag captures the result and clears Qj_busy. Same for Qk. Both CDBs are checked in parallel; if both match, the ALU CDB wins (cannot legally happen).
- Select: the lowest-index entry with busy=1, Qj_busy=0, Qk_busy=0 in registered state. That entry's fields load into the ALU_* registers, ALU_sgn=1, and its busy clears. If none is ready, ALU_sgn=0.
- Latency: issue at edge E0 with both operands ready → ALU_sgn high after E1. Wakeup at edge En → ALU_sgn high after En+1 at the earliest.
- Maximum one dispatch per cycle. Ordering is positional (lowest index), not age.
- Async reset mid-operation discards all entries; there is no partial dispatch.

Decomposition:
- defines.v (shared): opcode encodings (`ADD…`JALR), `ROBID, `RSSIZE, `True/`False. No local opcode constants.
- One sub-module, rs_select: combinational lowest-index priority encoder. Instantiated twice: on the free vector (alloc index plus full) and on the ready vector (dispatch index plus valid).

Test Plan:
- Reset, then issue ADD with Vj=5, Vk=7, both ready, rob=3 → one cycle later ALU_sgn=1 for exactly one cycle, ALU_opcode=`ADD, lhs=5, rhs=7, ROB_name=3.
- Issue SUB with Qj=2 pending, Vk=1; two cycles later CDB_sgn=1, tag 2, result 0x10 → next cycle ALU_sgn=1, lhs=0x10, rhs=1.
- Issue with Qj=4 pending while LSB_sgn=1, tag 4, result 9 in the same cycle → dispatch next cycle with lhs=9; no missed wakeup.
- Fill 16 entries all waiting on tag 7 → RS_full=1 and a 17th DC_sgn is ignored. Broadcast tag 7 → entries dispatch one per cycle in index order 0..15 over 16 cycles; RS_full drops after the first dispatch.
- Two ready entries at index 0 and 5, plus ROB_clear asserted alongside a new issue → nothing dispatches afterward, RS_full=0, and a later broadcast produces no ALU_sgn.
- rdy=0 for 3 cycles with one ready entry → ALU_sgn=0 and no state change; dispatch occurs one cycle after rdy returns. Async rst pulse mid-stream clears all ALU_* outputs immediately.
